// File: rtl/relu_row_serializer_pkg.sv
// Shared configuration and types for the relu row serializer.
//  ARRAYWIDTH_CFG : elements per output row
//  DATASIZE_CFG   : bits per element
//  IDX_W          : width of an element index within a row
//  ser_state_e    : serializer FSM encoding (IDLE=0, SEND=1)
package relu_row_serializer_pkg;

  localparam int ARRAYWIDTH_CFG = 4;
  localparam int DATASIZE_CFG   = 32;

  localparam int IDX_W    = $clog2(ARRAYWIDTH_CFG);
  localparam int CNTW_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/relu_row_serializer.sv
// relu_row_serializer: takes one post-ReLU row (ARRAYWIDTH elements of DATASIZE
// bits) per in_valid/in_ready handshake and emits it one element per beat on an
// out_valid/out_ready stream, element 0 first.
//  Ports:
//   clk, rst        clock (rising edge), async active-low reset
//   in_valid/ready  row handshake; in_data element k at [k*DATASIZE +: DATASIZE]
//   out_valid/ready element handshake; out_data, out_idx, out_last describe the beat
//   row_cnt         rows fully emitted, wraps at 2^CNTW
//  Optional feature macro RELU_SER_SKID_EN: adds a one-row skid register so a
//  second row can be accepted during SEND and rows stream with no idle bubble.
module relu_row_serializer
  import relu_row_serializer_pkg::*;
#(
  parameter int ARRAYWIDTH = ARRAYWIDTH_CFG,
  parameter int DATASIZE   = DATASIZE_CFG,
  parameter int CNTW       = CNTW_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ARRAYWIDTH*DATASIZE-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATASIZE-1:0]            out_data,
  output logic [$clog2(ARRAYWIDTH)-1:0]  out_idx,
  output logic                           out_last,
  output logic [CNTW-1:0]                row_cnt
);

  localparam int IW   = $clog2(ARRAYWIDTH);
  localparam int ROWW = ARRAYWIDTH * DATASIZE;

  ser_state_e        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [ROWW-1:0]   row_q, row_d;
  logic [CNTW-1:0]   cnt_d;
  // Holds in_ready low through reset and for the first edge after release.
  logic              rdy_q;

  logic fire, last, accept;

`ifdef RELU_SER_SKID_EN
  logic [ROWW-1:0]   skid_q, skid_d;
  logic              skid_full_q, skid_full_d;

  assign in_ready = rdy_q && !skid_full_q;
`else
  assign in_ready = rdy_q && (state_q == IDLE);
`endif

  assign out_valid = (state_q == SEND);
  assign last      = out_valid && (idx_q == IW'(ARRAYWIDTH - 1));
  assign fire      = out_valid && out_ready;
  assign accept    = in_valid && in_ready;

  assign out_data  = out_valid ? row_q[int'(idx_q)*DATASIZE +: DATASIZE] : '0;
  assign out_idx   = idx_q;
  assign out_last  = last;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    cnt_d   = row_cnt;
`ifdef RELU_SER_SKID_EN
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          row_d   = in_data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (fire) begin
          if (last) begin
            cnt_d = row_cnt + CNTW'(1);
            idx_d = '0;
`ifdef RELU_SER_SKID_EN
            // Refill row_reg on the final beat so the next row starts
            // with no idle cycle; skid first, otherwise a row arriving now.
            if (skid_full_q) begin
              row_d       = skid_q;
              skid_full_d = 1'b0;
            end else if (accept) begin
              row_d = in_data;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
`ifdef RELU_SER_SKID_EN
        // A row accepted while row_reg is still busy parks in the skid.
        if (accept && !(fire && last)) begin
          skid_d      = in_data;
          skid_full_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      row_q   <= '0;
      row_cnt <= '0;
      rdy_q   <= 1'b0;
`ifdef RELU_SER_SKID_EN
      skid_q      <= '0;
      skid_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      row_cnt <= cnt_d;
      rdy_q   <= 1'b1;
`ifdef RELU_SER_SKID_EN
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
`endif
    end
  end

endmodule

// File: tb/tb_relu_row_serializer.sv
// Scoreboard bench for relu_row_serializer (ARRAYWIDTH=4, DATASIZE=32).
// The driver pushes the expected beats of every accepted row; a negedge
// monitor pops and compares whenever a beat fires.
module tb_relu_row_serializer;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int IW = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [AW*DW-1:0]   in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [DW-1:0]      out_data;
  logic [IW-1:0]      out_idx;
  logic               out_last;
  logic [CW-1:0]      row_cnt;

  always #5 clk = ~clk;

  relu_row_serializer #(.ARRAYWIDTH(AW), .DATASIZE(DW), .CNTW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .row_cnt(row_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            idx;
    bit            last;
  } beat_t;

  beat_t         sb[$];
  int            fire_cyc[$];
  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            hs_cyc = 0;
  logic [CW-1:0] exp_rows = '0;

  // out_ready control: 0 = always 1, 1 = pattern over valid cycles, 2 = random
  int            ordy_mode = 0;
  int            pat_i = 0;
  bit            pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ordy_mode)
        1: begin
          if (pat_i >= 7) out_ready = 1'b1;
          else if (out_valid) begin
            out_ready = pat[pat_i];
            pat_i++;
          end else out_ready = 1'b0;
        end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: row_cnt model check, stall checks, beat pops.
  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      sb.delete();
      exp_rows = '0;
    end else begin
      chk("row_cnt_track", row_cnt, exp_rows);
      if (out_valid && !out_ready && sb.size() != 0) begin
        chk("stall_data", out_data, sb[0].data);
        chk("stall_idx", out_idx, sb[0].idx);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("extra_beat", 1, 0);
        else begin
          b = sb.pop_front();
          chk("beat_data", out_data, b.data);
          chk("beat_idx", out_idx, b.idx);
          chk("beat_last", out_last, b.last);
          if (b.last) exp_rows = exp_rows + 1'b1;
          fire_cyc.push_back(cyc);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_row(input logic [AW-1:0][DW-1:0] r);
    bit hs = 0;
    int t = 0;
    in_valid = 1'b1;
    in_data  = r;
    while (!hs && t < 200) begin
      @(negedge clk);
      hs = in_ready;
      if (hs) begin
        hs_cyc = cyc;
        for (int k = 0; k < AW; k++) sb.push_back('{r[k], k, k == AW - 1});
      end
      @(posedge clk);
      #1;
      t++;
    end
    if (!hs) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (sb.size() != 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0][DW-1:0] rand_row();
    logic [AW-1:0][DW-1:0] r;
    for (int k = 0; k < AW; k++) begin
      case ($urandom_range(0, 3))
        0: r[k] = '0;
        1: r[k] = '1;
        default: r[k] = $urandom;
      endcase
    end
    return r;
  endfunction

  initial begin
    logic [AW-1:0][DW-1:0] ra, rb;
    int span;

    // 1: reset
    in_valid = 1'b1;
    in_data  = '1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_row_cnt", row_cnt, 0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rel_in_ready_0", in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready_1", in_ready, 1);
    chk("rel_no_capture", out_valid, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // 2: single row, latency and consecutive beats
    ra = {32'h4, 32'h3, 32'h0, 32'h7F};
    fire_cyc.delete();
    send_row(ra);
    drain(50);
    chk("t2_beats", fire_cyc.size(), 4);
    if (fire_cyc.size() == 4) begin
      chk("t2_latency", fire_cyc[0], hs_cyc + 1);
      chk("t2_span", fire_cyc[3] - fire_cyc[0], 3);
    end
    chk("t2_row_cnt", row_cnt, 1);

    // 3: backpressure pattern 1,0,0,1,1,0,1
    pat_i = 0;
    ordy_mode = 1;
    fire_cyc.delete();
    send_row(ra);
    drain(50);
    chk("t3_beats", fire_cyc.size(), 4);
    if (fire_cyc.size() == 4) chk("t3_span", fire_cyc[3] - fire_cyc[0], 6);
    chk("t3_row_cnt", row_cnt, 2);
    ordy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // 4: back-to-back rows with in_valid held
    ra = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    rb = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    fire_cyc.delete();
    send_row(ra);
    send_row(rb);
    drain(50);
    chk("t4_beats", fire_cyc.size(), 8);
    if (fire_cyc.size() == 8) begin
      span = fire_cyc[7] - fire_cyc[0] + 1;
`ifdef RELU_SER_SKID_EN
      chk("t4_cycles", span, 8);
`else
      chk("t4_cycles", span, 9);
`endif
    end
    chk("t4_row_cnt", row_cnt, 4);

    // Random rows, gaps and backpressure
    ordy_mode = 2;
    for (int n = 0; n < 24; n++) begin
      send_row(rand_row());
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain(400);
    ordy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // 5: async reset mid-row
    fire_cyc.delete();
    send_row({32'h13, 32'h12, 32'h11, 32'h10});
    for (int t = 0; t < 50 && fire_cyc.size() < 2; t++) @(posedge clk);
    chk("t5_two_beats", fire_cyc.size(), 2);
    #3 rst = 1'b0;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_idx", out_idx, 0);
    chk("t5_out_last", out_last, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_row_cnt", row_cnt, 0);
    chk("t5_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_row({32'h23, 32'h22, 32'h21, 32'h20});
    drain(50);
    chk("t5_row_cnt_after", row_cnt, 1);

    // 6: row_cnt wrap
    force dut.row_cnt = 16'hFFFF;
    #1 release dut.row_cnt;
    exp_rows = 16'hFFFF;
    @(posedge clk);
    #1;
    send_row(rand_row());
    drain(50);
    chk("t6_wrap", row_cnt, 16'h0000);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
